// File: rtl/vga_pkg.sv
// Shared raster constants for the 800x600@60 (40 MHz) mode, used by this block and the draw stages.
package vga_pkg;

  localparam int CNT_W   = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int H_VIS = 800;
  localparam int H_FP  = 40;
  localparam int H_SW  = 128;
  localparam int H_BP  = 88;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;

  localparam int V_VIS = 600;
  localparam int V_FP  = 1;
  localparam int V_SW  = 4;
  localparam int V_BP  = 23;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  function automatic bit fits_cnt(input int total);
    return (total > 0) && (total <= CNT_MAX);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-stream timing bus: raster position plus sync/blank decodes and frame-start strobe.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] hcount_out;
  logic             hsync_out;
  logic             hblnk_out;
  logic [CNT_W-1:0] vcount_out;
  logic             vsync_out;
  logic             vblnk_out;
  logic             frame_start;

  modport master (
    output hcount_out, hsync_out, hblnk_out,
    output vcount_out, vsync_out, vblnk_out,
    output frame_start
  );

  modport slave (
    input hcount_out, hsync_out, hblnk_out,
    input vcount_out, vsync_out, vblnk_out,
    input frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter with blank/sync decodes registered from the next count.
// Zero latency between count and decodes; advances only when carry_in is high.
module vga_axis_counter #(
  parameter int TOTAL      = 1056,
  parameter int VISIBLE    = 800,
  parameter int SYNC_START = 840,
  parameter int SYNC_LEN   = 128,
  parameter bit POL        = 1'b1,
  parameter int W          = 12
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         carry_in,
  output logic [W-1:0] count,
  output logic         blank,
  output logic         sync,
  output logic         carry_out
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS  = W'(VISIBLE);
  localparam logic [W-1:0] SS   = W'(SYNC_START);
  localparam logic [W-1:0] SE   = W'(SYNC_START + SYNC_LEN);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] nxt;
  logic         in_sync;

  // Terminal count is unqualified; the parent gates it with its own enable.
  assign carry_out = (count == LAST);
  assign nxt       = carry_out ? '0 : count + ONE;
  assign in_sync   = (nxt >= SS) && (nxt < SE);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      count <= '0;
      blank <= 1'b0;
      sync  <= ~POL;
    end else if (carry_in) begin
      count <= nxt;
      blank <= (nxt >= VIS);
      sync  <= in_sync ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing source; all outputs registered, decodes aligned with counts.
// Advances only on pix_ce; no backpressure from downstream.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VIS,
  parameter int H_FRONT   = H_FP,
  parameter int H_SYNC    = H_SW,
  parameter int H_BACK    = H_BP,
  parameter int V_VISIBLE = V_VIS,
  parameter int V_FRONT   = V_FP,
  parameter int V_SYNC    = V_SW,
  parameter int V_BACK    = V_BP,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              pix_ce,
  vga_timing_gen_if.master  tim
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SS    = H_VISIBLE + H_FRONT;
  localparam int V_SS    = V_VISIBLE + V_FRONT;

  if (!fits_cnt(H_TOTAL) || !fits_cnt(V_TOTAL)) begin : g_range_check
    $error("vga_timing_gen: raster totals must fit the 12-bit counters");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_blnk;
  logic             h_sync;
  logic             v_blnk;
  logic             v_sync;
  logic             h_co;
  logic             v_co;
  logic             v_en;
  logic             frame_q;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_SS),
    .SYNC_LEN   (H_SYNC),
    .POL        (HSYNC_POL),
    .W          (CNT_W)
  ) u_h_axis (
    .clk_in    (clk_in),
    .rst       (rst),
    .carry_in  (pix_ce),
    .count     (h_cnt),
    .blank     (h_blnk),
    .sync      (h_sync),
    .carry_out (h_co)
  );

  assign v_en = pix_ce & h_co;

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_SS),
    .SYNC_LEN   (V_SYNC),
    .POL        (VSYNC_POL),
    .W          (CNT_W)
  ) u_v_axis (
    .clk_in    (clk_in),
    .rst       (rst),
    .carry_in  (v_en),
    .count     (v_cnt),
    .blank     (v_blnk),
    .sync      (v_sync),
    .carry_out (v_co)
  );

  // Both axes wrapping on an enabled edge means the raster is entering (0,0).
  always_ff @(posedge clk_in) begin
    if (rst) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= v_en & v_co;
    end
  end

  assign tim.hcount_out  = h_cnt;
  assign tim.hsync_out   = h_sync;
  assign tim.hblnk_out   = h_blnk;
  assign tim.vcount_out  = v_cnt;
  assign tim.vsync_out   = v_sync;
  assign tim.vblnk_out   = v_blnk;
  assign tim.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench: a default-mode instance and a tiny active-low-sync instance for frame-level cases.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int A_HT = 1056, A_VT = 628;
  localparam int A_HV = 800,  A_HSS = 840, A_HSW = 128;
  localparam int A_VV = 600,  A_VSS = 601, A_VSW = 4;

  localparam int B_HT = 15, B_VT = 12;
  localparam int B_HV = 8,  B_HSS = 10, B_HSW = 3;
  localparam int B_VV = 6,  B_VSS = 7,  B_VSW = 2;

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } obs_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_a = 1'b1, ce_a = 1'b0;
  logic rst_b = 1'b1, ce_b = 1'b0;

  vga_timing_gen_if tim_a ();
  vga_timing_gen_if tim_b ();

  vga_timing_gen dut_a (
    .clk_in (clk_in),
    .rst    (rst_a),
    .pix_ce (ce_a),
    .tim    (tim_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) dut_b (
    .clk_in (clk_in),
    .rst    (rst_b),
    .pix_ce (ce_b),
    .tim    (tim_b)
  );

  obs_t q_a[$];
  obs_t q_b[$];
  int checks = 0;
  int errors = 0;

  int mh_a = 0, mv_a = 0, mh_b = 0, mv_b = 0;

  int hs_a = 0, hb_a = 0, fs_a = 0;
  int fs_b = 0, gap_b = 0, last_fs_b = -1, vs_low_b = 0, cyc = 0;

  function automatic obs_t expect_obs(input int h, input int v, input bit fs,
                                      input int hv, input int hss, input int hsw,
                                      input int vv, input int vss, input int vsw,
                                      input bit hp, input bit vp);
    obs_t o;
    o.h  = 12'(h);
    o.v  = 12'(v);
    o.hb = (h >= hv);
    o.hs = (h >= hss && h < hss + hsw) ? hp : ~hp;
    o.vb = (v >= vv);
    o.vs = (v >= vss && v < vss + vsw) ? vp : ~vp;
    o.fs = fs;
    return o;
  endfunction

  task automatic adv(input int ht, input int vt, input bit r, input bit c,
                     inout int h, inout int v, output bit fs);
    fs = 1'b0;
    if (r) begin
      h = 0;
      v = 0;
    end else if (c) begin
      if (h == ht - 1) begin
        h = 0;
        if (v == vt - 1) begin
          v  = 0;
          fs = 1'b1;
        end else begin
          v = v + 1;
        end
      end else begin
        h = h + 1;
      end
    end
  endtask

  task automatic step(input bit ra, input bit ca, input bit rb, input bit cb);
    bit fa, fb;
    @(negedge clk_in);
    rst_a = ra; ce_a = ca; rst_b = rb; ce_b = cb;
    adv(A_HT, A_VT, ra, ca, mh_a, mv_a, fa);
    q_a.push_back(expect_obs(mh_a, mv_a, fa, A_HV, A_HSS, A_HSW, A_VV, A_VSS, A_VSW, 1'b1, 1'b1));
    adv(B_HT, B_VT, rb, cb, mh_b, mv_b, fb);
    q_b.push_back(expect_obs(mh_b, mv_b, fb, B_HV, B_HSS, B_HSW, B_VV, B_VSS, B_VSW, 1'b0, 1'b0));
  endtask

  task automatic run(input int n, input bit ra, input bit ca, input bit rb, input bit cb);
    repeat (n) step(ra, ca, rb, cb);
  endtask

  task automatic settle();
    @(posedge clk_in);
    #4;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected observation per instance each cycle.
  initial begin
    obs_t e, act;
    forever begin
      @(posedge clk_in);
      #2;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        act = '{tim_a.hcount_out, tim_a.vcount_out, tim_a.hsync_out, tim_a.hblnk_out,
                tim_a.vsync_out, tim_a.vblnk_out, tim_a.frame_start};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL obs_a t=%0t got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b, expected h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
                   $time, act.h, act.v, act.hs, act.hb, act.vs, act.vb, act.fs,
                   e.h, e.v, e.hs, e.hb, e.vs, e.vb, e.fs);
        end
        if (act.v == 12'd0 && act.hs === 1'b1) hs_a++;
        if (act.v == 12'd0 && act.hb === 1'b1) hb_a++;
        if (act.fs === 1'b1) fs_a++;
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        act = '{tim_b.hcount_out, tim_b.vcount_out, tim_b.hsync_out, tim_b.hblnk_out,
                tim_b.vsync_out, tim_b.vblnk_out, tim_b.frame_start};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL obs_b t=%0t got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b, expected h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
                   $time, act.h, act.v, act.hs, act.hb, act.vs, act.vb, act.fs,
                   e.h, e.v, e.hs, e.hb, e.vs, e.vb, e.fs);
        end
        if (act.fs === 1'b1) begin
          fs_b++;
          if (last_fs_b >= 0) gap_b = cyc - last_fs_b;
          last_fs_b = cyc;
        end
        if (act.vs === 1'b0) vs_low_b++;
      end
      cyc++;
    end
  end

  initial begin
    int fs_before;

    // Reset both instances.
    run(2, 1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    chk("rst_a_hsync", int'(tim_a.hsync_out), 0);
    chk("rst_b_hsync_pol0", int'(tim_b.hsync_out), 1);
    chk("rst_b_vsync_pol0", int'(tim_b.vsync_out), 1);

    // One full line on A; many frames on B.
    run(1060, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("a_hsync_cycles_line0", hs_a, 128);
    chk("a_hblnk_cycles_line0", hb_a, 256);
    chk("a_pos_after_1060_h", int'(tim_a.hcount_out), 4);
    chk("a_pos_after_1060_v", int'(tim_a.vcount_out), 1);
    chk("b_frame_pulses", fs_b, 5);
    chk("b_frame_period", gap_b, 180);
    chk("b_vsync_active_cycles", vs_low_b, 180);

    // A: mid-frame reset, advance to 799, stall twice, then cross into blanking.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    run(799, 1'b0, 1'b1, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0, 1'b0);
    run(6, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("a_h_after_stall", int'(tim_a.hcount_out), 805);
    chk("a_hblnk_after_stall", int'(tim_a.hblnk_out), 1);
    chk("a_no_frame_pulse", fs_a, 0);

    // B: park at the last pixel of the frame, stall, then wrap.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    run(179, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    fs_before = fs_b;
    chk("b_parked_h", int'(tim_b.hcount_out), 14);
    chk("b_parked_v", int'(tim_b.vcount_out), 11);
    run(3, 1'b0, 1'b0, 1'b0, 1'b0);
    run(4, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("b_single_pulse_at_wrap", fs_b - fs_before, 1);

    // B: reset at (5,3), with reset overriding an active enable, then resume.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    run(50, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("b_h_after_midframe_rst", int'(tim_b.hcount_out), 3);
    chk("b_v_after_midframe_rst", int'(tim_b.vcount_out), 0);
    chk("b_hsync_inactive", int'(tim_b.hsync_out), 1);

    settle();
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
